// File: rtl/lut_array_pkg.sv
//------------------------------------------------------------------------------
// Module  : lut_array_pkg
// Brief   : Shared types and helpers for the LUT neuron array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lut_array_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_neuron_array_pipe_if.sv
//------------------------------------------------------------------------------
// Module  : lut_neuron_array_pipe_if
// Brief   : Stream and table-config bundle of the LUT neuron array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lut_neuron_array_pipe_if #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1,
    parameter int NIDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
    logic                          s_valid;
    logic                          s_ready;
    logic [N_NEURONS*IN_BITS-1:0]  s_data;
    logic                          m_valid;
    logic                          m_ready;
    logic [N_NEURONS*OUT_BITS-1:0] m_data;
    logic                          cfg_we;
    logic [NIDX_W-1:0]             cfg_neuron;
    logic [IN_BITS-1:0]            cfg_addr;
    logic [OUT_BITS-1:0]           cfg_wdata;
    logic                          cfg_clear;
    logic                          cfg_busy;

    modport master (
        output s_valid, s_data, m_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata, cfg_clear,
        input  s_ready, m_valid, m_data, cfg_busy
    );

    modport slave (
        input  s_valid, s_data, m_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata, cfg_clear,
        output s_ready, m_valid, m_data, cfg_busy
    );
endinterface

`default_nettype wire

// File: rtl/lut_neuron_ram.sv
//------------------------------------------------------------------------------
// Module  : lut_neuron_ram
// Brief   : One neuron truth table: sync write port, async read port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_neuron_ram
    import lut_array_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  wire logic                clk,
    input  wire logic                we,
    input  wire logic [IN_BITS-1:0]  waddr,
    input  wire logic [OUT_BITS-1:0] wdata,
    input  wire logic [IN_BITS-1:0]  raddr,
    output logic      [OUT_BITS-1:0] rdata
);
    localparam int TABLE_DEPTH = table_depth(IN_BITS);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem_q [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Async read sees the pre-edge contents, so a colliding write is read-before-write.
    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/lut_neuron_array_pipe.sv
//------------------------------------------------------------------------------
// Module  : lut_neuron_array_pipe
// Brief   : Array of run-time-programmable truth-table neurons, 1-cycle stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_neuron_array_pipe
    import lut_array_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1,
    parameter int NIDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    lut_neuron_array_pipe_if.slave bus
);
    localparam int               TABLE_DEPTH = table_depth(IN_BITS);
    localparam logic [IN_BITS:0] CLR_LAST    = (IN_BITS+1)'(TABLE_DEPTH - 1);
    localparam logic [IN_BITS:0] CLR_ONE     = (IN_BITS+1)'(1);

    state_t                        state_q, state_d;
    logic [IN_BITS:0]              clr_cnt_q, clr_cnt_d;
    logic                          m_valid_q, m_valid_d;
    logic [N_NEURONS*OUT_BITS-1:0] m_data_q, m_data_d;

    logic                          w_s_ready;
    logic                          w_accept;
    logic [N_NEURONS-1:0]          w_ram_we;
    logic [IN_BITS-1:0]            w_ram_waddr;
    logic [OUT_BITS-1:0]           w_ram_wdata;
    logic [N_NEURONS*OUT_BITS-1:0] w_lookup;

    assign w_s_ready = (state_q == ST_RUN) && (!m_valid_q || bus.m_ready);
    assign w_accept  = bus.s_valid && w_s_ready;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        w_ram_we    = '0;
        w_ram_waddr = bus.cfg_addr;
        w_ram_wdata = bus.cfg_wdata;
        case (state_q)
            ST_CLEAR: begin
                w_ram_we    = '1;
                w_ram_waddr = clr_cnt_q[IN_BITS-1:0];
                w_ram_wdata = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_ONE;
                end
            end
            ST_RUN: begin
                // Out-of-range neuron indices match no table and are dropped.
                for (int n = 0; n < N_NEURONS; n++) begin
                    w_ram_we[n] = bus.cfg_we && (bus.cfg_neuron == NIDX_W'(n));
                end
                if (bus.cfg_clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (w_accept) begin
            m_valid_d = 1'b1;
            m_data_d  = w_lookup;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        lut_neuron_ram #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk   (clk),
            .we    (w_ram_we[n]),
            .waddr (w_ram_waddr),
            .wdata (w_ram_wdata),
            .raddr (bus.s_data[n*IN_BITS +: IN_BITS]),
            .rdata (w_lookup[n*OUT_BITS +: OUT_BITS])
        );
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.cfg_busy = (state_q == ST_CLEAR);

endmodule

`default_nettype wire
